// File: rtl/button_event_scheduler_pkg.sv
// Shared defaults and index arithmetic for the button event scheduler.
package button_event_scheduler_pkg;

  localparam int unsigned DEF_N_INPUTS = 4;

  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/button_event_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap-around.
module button_event_scheduler_rr_pick
  import button_event_scheduler_pkg::*;
#(
  parameter  int unsigned N_INPUTS = DEF_N_INPUTS,
  localparam int unsigned IDX_W    = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic                any,
  output logic [IDX_W-1:0]    idx
);

  logic [N_INPUTS-1:0] rot;
  int unsigned         base;
  int unsigned         off;

  always_comb begin
    base = 32'(last);
    rot  = '0;
    off  = 0;
    // rot[0] is the slot just after the previous grant
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      rot[k] = req[IDX_W'(wrap_idx(base, k + 1, N_INPUTS))];
    end
    for (int k = int'(N_INPUTS) - 1; k >= 0; k--) begin
      if (rot[k]) off = 32'(k);
    end
    any = |req;
    idx = IDX_W'(wrap_idx(base, off + 1, N_INPUTS));
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Latches edge pulses as pending events and serves them round-robin over valid/ready.
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter  int unsigned N_INPUTS = DEF_N_INPUTS,
  localparam int unsigned IDX_W    = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] edge_pulse,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [IDX_W-1:0]    event_id,
  output logic [N_INPUTS-1:0] overrun,
  input  logic                overrun_clear
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_INPUTS - 1);

  logic [N_INPUTS-1:0] pending_q, pending_d;
  logic [N_INPUTS-1:0] overrun_q, overrun_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    id_q, id_d;

  logic                slot_free;
  logic                grant;
  logic [N_INPUTS-1:0] grant_vec;
  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;

  button_event_scheduler_rr_pick #(.N_INPUTS(N_INPUTS)) u_pick (
    .req  (pending_q),
    .last (last_grant_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    slot_free = !valid_q || event_ready;
    grant     = slot_free && pick_any;
    grant_vec = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      grant_vec[i] = grant && (pick_idx == IDX_W'(i));
    end
    // a pulse on the source being granted this cycle is a fresh event, not an overrun
    pending_d    = (pending_q & ~grant_vec) | edge_pulse;
    overrun_d    = (overrun_clear ? '0 : overrun_q) | (edge_pulse & pending_q & ~grant_vec);
    valid_d      = valid_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (slot_free) valid_d = pick_any;
    if (grant) begin
      id_d         = pick_idx;
      last_grant_d = pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      overrun_q    <= '0;
      last_grant_q <= LAST_RST;
      valid_q      <= 1'b0;
      id_q         <= '0;
    end else begin
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
    end
  end

  assign event_valid = valid_q;
  assign event_id    = id_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed scenarios plus random traffic against an event-level reference model.
module tb_button_event_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] edge_pulse = '0;
  logic         event_valid;
  logic         event_ready = 1'b0;
  logic [1:0]   event_id;
  logic [N-1:0] overrun;
  logic         overrun_clear = 1'b0;

  always #5 clk = ~clk;

  button_event_scheduler #(.N_INPUTS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .edge_pulse    (edge_pulse),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_id      (event_id),
    .overrun       (overrun),
    .overrun_clear (overrun_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit m_pend [N];
  bit m_ov   [N];
  int m_last;
  bit m_valid;
  int m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ov_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ov[i];
    return v;
  endfunction

  // One clock of the reference model, evaluated on pre-edge inputs and state.
  task automatic model_step(input logic [N-1:0] ep, input logic rdy, input logic clr, input logic r);
    int g;
    bit free;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ov[i]   = 0;
      end
      m_last  = N - 1;
      m_valid = 0;
      m_id    = 0;
      return;
    end
    free = !m_valid || rdy;
    g    = -1;
    if (free) begin
      for (int s = 1; s <= N; s++) begin
        if (g < 0 && m_pend[(m_last + s) % N]) g = (m_last + s) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit lost;
      lost = ep[i] && m_pend[i] && (i != g);
      m_ov[i] = (clr ? 1'b0 : m_ov[i]) | lost;
      if (i == g) m_pend[i] = 0;
      if (ep[i]) m_pend[i] = 1;
    end
    if (free) begin
      if (g >= 0) begin
        m_valid = 1;
        m_id    = g;
        m_last  = g;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic cycle(input logic [N-1:0] ep, input logic rdy, input logic clr, input logic r);
    edge_pulse    = ep;
    event_ready   = rdy;
    overrun_clear = clr;
    rst           = r;
    @(posedge clk);
    model_step(ep, rdy, clr, r);
    #1;
    chk("model_valid", event_valid, m_valid);
    chk("model_id", event_id, m_id);
    chk("model_overrun", overrun, ov_vec());
  endtask

  initial begin
    int cnt [N];

    // reset and basic single event
    cycle(4'b0000, 1, 0, 1);
    chk("rst_valid", event_valid, 0);
    chk("rst_id", event_id, 0);
    chk("rst_overrun", overrun, 0);
    cycle(4'b0000, 1, 0, 1);
    cycle(4'b0000, 1, 0, 1);
    cycle(4'b0000, 1, 0, 0);
    cycle(4'b0100, 1, 0, 0);
    chk("basic_not_yet", event_valid, 0);
    cycle(4'b0000, 1, 0, 0);
    chk("basic_valid", event_valid, 1);
    chk("basic_id", event_id, 2);
    cycle(4'b0000, 1, 0, 0);
    chk("basic_drop", event_valid, 0);
    chk("basic_overrun", overrun, 0);

    // burst from a fresh pointer
    cycle(4'b0000, 1, 0, 1);
    cycle(4'b1011, 1, 0, 0);
    chk("burst_lat", event_valid, 0);
    cycle(4'b0000, 1, 0, 0);
    chk("burst_id0", event_id, 0);
    cycle(4'b0000, 1, 0, 0);
    chk("burst_id1", event_id, 1);
    chk("burst_v1", event_valid, 1);
    cycle(4'b0000, 1, 0, 0);
    chk("burst_id3", event_id, 3);
    cycle(4'b0000, 1, 0, 0);
    chk("burst_end", event_valid, 0);

    // wrap after a grant of 3
    cycle(4'b1001, 1, 0, 0);
    cycle(4'b0000, 1, 0, 0);
    chk("wrap_g0", event_id, 0);
    cycle(4'b0001, 1, 0, 0);
    chk("wrap_g1", event_id, 3);
    cycle(4'b1000, 1, 0, 0);
    chk("wrap_g2", event_id, 0);
    cycle(4'b0000, 1, 0, 0);
    chk("wrap_g3", event_id, 3);
    chk("wrap_v3", event_valid, 1);
    cycle(4'b0000, 1, 0, 0);

    // re-pulse in the grant cycle
    cycle(4'b0100, 1, 0, 0);
    cycle(4'b0100, 1, 0, 0);
    chk("repulse_id_a", event_id, 2);
    cycle(4'b0000, 1, 0, 0);
    chk("repulse_v_b", event_valid, 1);
    chk("repulse_id_b", event_id, 2);
    cycle(4'b0000, 1, 0, 0);
    chk("repulse_end", event_valid, 0);
    chk("repulse_ovr", overrun, 0);

    // backpressure and overrun
    cycle(4'b0010, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    chk("bp_held_id", event_id, 1);
    cycle(4'b0000, 0, 0, 0);
    chk("bp_stable_v", event_valid, 1);
    chk("bp_stable_id", event_id, 1);
    cycle(4'b0010, 0, 0, 0);
    chk("bp_no_ovr", overrun, 0);
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0010, 0, 0, 0);
    chk("bp_ovr", overrun, 4'b0010);
    cycle(4'b0000, 1, 0, 0);
    chk("bp_second_v", event_valid, 1);
    chk("bp_second_id", event_id, 1);
    cycle(4'b0000, 1, 0, 0);
    chk("bp_done", event_valid, 0);
    chk("bp_ovr_sticky", overrun, 4'b0010);
    cycle(4'b0000, 1, 1, 0);
    chk("bp_ovr_clear", overrun, 0);

    // overrun set beats a simultaneous clear
    cycle(4'b0001, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0001, 0, 0, 0);
    cycle(4'b0001, 0, 1, 0);
    chk("setwins_ovr", overrun, 4'b0001);
    cycle(4'b0000, 1, 1, 0);
    chk("setwins_clr", overrun, 0);
    cycle(4'b0000, 1, 0, 0);

    // reset mid-operation
    cycle(4'b1111, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    cycle(4'b0010, 0, 0, 0);
    chk("midrst_pre_v", event_valid, 1);
    cycle(4'b0000, 0, 0, 1);
    chk("midrst_v", event_valid, 0);
    chk("midrst_ovr", overrun, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 1, 0, 0);
      chk("midrst_quiet", event_valid, 0);
    end
    cycle(4'b1000, 1, 0, 0);
    cycle(4'b0000, 1, 0, 0);
    chk("midrst_next_id", event_id, 3);
    cycle(4'b0000, 1, 1, 0);

    // fairness with every source continuously pending
    for (int i = 0; i < N; i++) cnt[i] = 0;
    cycle(4'b1111, 1, 0, 0);
    for (int k = 0; k < 2 * N; k++) begin
      cycle(4'b1111, 1, 0, 0);
      if (event_valid === 1'b1 && event_id !== 2'bxx) cnt[event_id]++;
    end
    for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 2);
    cycle(4'b0000, 1, 1, 1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      cycle(4'($urandom & $urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
